// File: rtl/apb_rr_pkg.sv
// Shared types and default sizing for the two-requester APB master slice.
package apb_rr_pkg;

  localparam int DEF_ADDR_W      = 3;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_REG     = 8;
  localparam int DEF_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_rr_master_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot winner, last-grant pointer
// advances whenever a strobed arbitration actually grants someone.
module rr_arb2 (
  input  logic pclk,
  input  logic preset_n,
  input  logic req0,
  input  logic req1,
  input  logic arb,
  output logic win0,
  output logic win1
);

  logic last;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win0 = req0 && (!req1 || last);
    win1 = req1 && (!req0 || !last);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      last <= 1'b1;
    end else if (arb && (req0 || req1)) begin
      last <= win1;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing the register bank between two requesters (round-robin).
// Optional ACCESS wait-state abort is enabled by defining APB_RR_MASTER_TIMEOUT_EN.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_REG = DEF_NUM_REG
`ifdef APB_RR_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               wr0,
  input  logic               wr1,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  wdata0,
  input  logic [DATA_W-1:0]  wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic               err,
  output logic [DATA_W-1:0]  rdata,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [NUM_REG-1:0] select_reg,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  state_t state;
  logic   owner;
  logic   win0, win1;
  logic   any_req, arb, start, complete, timeout;

  // Out-of-range indices select nothing; the transfer still runs on the bus.
  function automatic logic [NUM_REG-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_REG-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (int'(a) == i) s[i] = 1'b1;
    end
    return s;
  endfunction

  assign any_req  = req0 | req1;
  assign complete = (state == ACCESS) && (pready || timeout);
  assign arb      = (state == IDLE) || complete;
  assign start    = arb && any_req;

  rr_arb2 u_arb (
    .pclk     (pclk),
    .preset_n (preset_n),
    .req0     (req0),
    .req1     (req1),
    .arb      (arb),
    .win0     (win0),
    .win1     (win1)
  );

`ifdef APB_RR_MASTER_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Abort on the edge where the count of pready-low ACCESS cycles reaches the limit.
  assign timeout = !pready && (wait_cnt == 4'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      select_reg <= '0;
      pwdata     <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;

      if (complete) begin
        done0 <= !owner;
        done1 <= owner;
        err   <= pready ? pslverr : 1'b1;
        if (pready && !pwrite) rdata <= prdata;
      end

      // A new transfer may start from IDLE or directly off a completion edge.
      if (start) begin
        state      <= SETUP;
        owner      <= win1;
        psel       <= 1'b1;
        penable    <= 1'b0;
        pwrite     <= win1 ? wr1 : wr0;
        pwdata     <= win1 ? wdata1 : wdata0;
        select_reg <= decode(win1 ? addr1 : addr0);
        gnt0       <= win0;
        gnt1       <= win1;
      end else begin
        case (state)
          IDLE: ;
          SETUP: begin
            penable <= 1'b1;
            state   <= ACCESS;
          end
          ACCESS: begin
            if (complete) begin
              state      <= IDLE;
              psel       <= 1'b0;
              penable    <= 1'b0;
              select_reg <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master: stimulus queues expected grants/completions,
// a monitor pops them whenever the DUT pulses gnt/done. Define APB_RR_MASTER_TIMEOUT_EN for the abort case.
module tb_apb_rr_master;

  logic       pclk, preset_n;
  logic       req0, req1, wr0, wr1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1, err;
  logic [7:0] rdata;
  logic       psel, penable, pwrite;
  logic [7:0] select_reg, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;

  typedef struct {
    int       id;
    bit       err;
    bit       rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  int         cur_wait = 0;
  logic       cur_err = 1'b0;
  logic [7:0] cur_rdata = 8'h00;

  apb_rr_master dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .req0       (req0),
    .req1       (req1),
    .wr0        (wr0),
    .wr1        (wr1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .err        (err),
    .rdata      (rdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .select_reg (select_reg),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave: holds pready low for cur_wait ACCESS cycles, then completes.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge pclk);
      prdata  = cur_rdata;
      pslverr = cur_err;
      if (psel && penable) begin
        pready = (wcnt >= cur_wait);
        wcnt++;
      end else begin
        pready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever a grant or completion is presented.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(posedge pclk);
      #1;
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {30'b0, done1, done0}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_id", {30'b0, done1, done0}, (e.id == 1) ? 2 : 1);
          chk("done_err", err, e.err);
          if (e.rd) chk("done_rdata", rdata, e.rdata);
        end
      end
      if (gnt0 || gnt1) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", {30'b0, gnt1, gnt0}, 0);
        end else begin
          g = gnt_q.pop_front();
          chk("gnt_id", {30'b0, gnt1, gnt0}, (g == 1) ? 2 : 1);
        end
      end
    end
  end

  // Raise one request, wait (bounded) for its grant, then drop it in the SETUP cycle.
  task automatic issue(input int id, input bit wr, input logic [2:0] a, input logic [7:0] d,
                       input bit push_done, input bit e_err, input logic [7:0] e_rd);
    int k;
    @(negedge pclk);
    if (id == 0) begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
    gnt_q.push_back(id);
    if (push_done) exp_q.push_back('{id, e_err, !wr, e_rd});
    k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (!((id == 0) ? gnt0 : gnt1) && k < 20);
    chk("gnt_seen", (id == 0) ? gnt0 : gnt1, 1);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (!(done0 || done1) && k < 40);
    chk("done_seen", done0 | done1, 1);
  endtask

  // Both requesters held high until each has n grants.
  task automatic contend(input int n);
    int c0, c1, cyc, first, lastg, gap;
    bit started;
    c0 = 0; c1 = 0; cyc = 0; first = 0; lastg = 0; gap = 0; started = 0;
    @(negedge pclk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd2; wdata0 = 8'h11;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd6; wdata1 = 8'h22;
    for (int i = 0; i < n; i++) begin
      gnt_q.push_back(0);
      gnt_q.push_back(1);
      exp_q.push_back('{0, 1'b0, 1'b0, 8'h00});
      exp_q.push_back('{1, 1'b0, 1'b0, 8'h00});
    end
    for (int k = 0; k < 60 && (c0 < n || c1 < n); k++) begin
      @(negedge pclk);
      cyc++;
      if (started && !psel) gap++;
      if (gnt0 || gnt1) begin
        if (!started) first = cyc;
        started = 1'b1;
        lastg = cyc;
      end
      if (gnt0) begin c0++; if (c0 == n) req0 = 1'b0; end
      if (gnt1) begin c1++; if (c1 == n) req1 = 1'b0; end
    end
    chk("contend_gnt0_cnt", c0, n);
    chk("contend_gnt1_cnt", c1, n);
    chk("contend_span", lastg - first, 2 * (2 * n - 1));
    chk("contend_psel_gap", gap, 0);
    wait_done();
    @(negedge pclk);
    chk("contend_idle_psel", psel, 0);
  endtask

  initial begin
    preset_n = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    prdata = 0; pready = 0; pslverr = 0;
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_select", select_reg, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_gnt_done", {gnt0, gnt1, done0, done1}, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;

    // Contention from reset: order 0,1,0,1 back-to-back.
    contend(2);

    // Single write with no wait states.
    issue(0, 1'b1, 3'd3, 8'hA5, 1'b1, 1'b0, 8'h00);
    chk("w1_setup_select", select_reg, 8'h08);
    chk("w1_setup_pwdata", pwdata, 8'hA5);
    chk("w1_setup_ctrl", {psel, penable, pwrite}, 3'b101);
    @(negedge pclk);
    chk("w1_access_ctrl", {psel, penable, gnt0}, 3'b110);
    chk("w1_access_select", select_reg, 8'h08);
    chk("w1_access_pwdata", pwdata, 8'hA5);
    @(negedge pclk);
    chk("w1_done", {done0, err}, 2'b10);
    chk("w1_idle", {psel, penable, select_reg}, 0);

    // Three wait states.
    cur_wait = 3;
    issue(0, 1'b1, 3'd1, 8'h5A, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("ws_hold", {psel, penable, done0, select_reg}, {3'b110, 8'h02});
    end
    @(negedge pclk);
    chk("ws_done", done0, 1);
    cur_wait = 0;

    // Read with slave error from requester 1.
    cur_err = 1'b1;
    cur_rdata = 8'h3C;
    issue(1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b1, 8'h3C);
    wait_done();
    chk("err_rd_flags", {done1, err}, 2'b11);
    chk("err_rd_rdata", rdata, 8'h3C);
    cur_err = 1'b0;
    cur_rdata = 8'hEE;

    // A write must leave rdata untouched.
    issue(0, 1'b1, 3'd7, 8'h77, 1'b1, 1'b0, 8'h00);
    wait_done();
    chk("rdata_hold", rdata, 8'h3C);

    // Reset in the middle of ACCESS abandons the transfer.
    cur_wait = 5;
    issue(0, 1'b1, 3'd4, 8'h99, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge pclk);
    #2;
    preset_n = 1'b0;
    #1;
    chk("midrst_bus", {psel, penable, pwrite, select_reg, pwdata}, 0);
    chk("midrst_flags", {gnt0, gnt1, done0, done1, err}, 0);
    cur_wait = 0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    chk("midrst_idle", psel, 0);
    contend(1);

`ifdef APB_RR_MASTER_TIMEOUT_EN
    // Slave never ready: abort after 15 wait cycles, then serve requester 1.
    cur_wait = 1000;
    issue(0, 1'b1, 3'd3, 8'hC3, 1'b1, 1'b1, 8'h00);
    req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd0;
    cur_rdata = 8'h5A;
    gnt_q.push_back(1);
    exp_q.push_back('{1, 1'b0, 1'b1, 8'h5A});
    for (int i = 0; i < 15; i++) begin
      @(negedge pclk);
      chk("to_wait", done0, 0);
    end
    @(negedge pclk);
    chk("to_abort", {done0, err, gnt1}, 3'b111);
    cur_wait = 0;
    req1 = 1'b0;
    wait_done();
    chk("to_next_rdata", rdata, 8'h5A);
`endif

    repeat (3) @(negedge pclk);
    chk("left_done_exp", exp_q.size(), 0);
    chk("left_gnt_exp", gnt_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
